dcm_clkgen_prog: RTL and testbench

- Initiator for the DCM_CLKGEN serial M/D reprogramming port (PROGCLK/PROGDATA/PROGEN/PROGDONE). Our existing DCM wrappers tie this port off.
- Loads a new CLKFX multiply/divide pair at run time, issues GO, then waits for PROGDONE and LOCKED.
- Sits between control logic (register bank or UART command decoder) and a DCM_CLKGEN instance whose RST is held low.

---
 rtl/dcm_prog_pkg.sv | 35 +++
 rtl/dcm_clkgen_prog_sync2.sv | 19 +
 rtl/dcm_clkgen_prog.sv | 204 ++++++++++++++++++++
 tb/tb_dcm_clkgen_prog.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcm_prog_pkg.sv
// Shared definitions for the DCM_CLKGEN M/D reprogramming initiator:
// FSM state encoding, serial command codes, load field length and
// error codes.
package dcm_prog_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_D,
    ST_GAP1,
    ST_LOAD_M,
    ST_GAP2,
    ST_GO,
    ST_WAIT_DONE,
    ST_WAIT_LOCK,
    ST_FINISH
  } state_e;

  // Command codes, shifted LSB first ahead of the 8 value bits
  localparam logic [1:0] CMD_LOAD_D = 2'b01;
  localparam logic [1:0] CMD_LOAD_M = 2'b11;

  localparam int unsigned LOAD_BITS = 10;
  localparam int unsigned BIT_CNT_W = 4;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_M   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // A load field in transmit order: bit 0 goes out first
  function automatic logic [LOAD_BITS-1:0] load_word(input logic [1:0] cmd,
                                                      input logic [7:0] val);
    return {val, cmd};
  endfunction

endpackage

// File: rtl/dcm_clkgen_prog_sync2.sv
// Two-flop synchroniser for a single asynchronous level into clk_i.
// Ports: clk_i, rst_ni (async active-low), d_i (async in), q_o (synced out).
module dcm_clkgen_prog_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= 2'b00;
    else         sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/dcm_clkgen_prog.sv
// DCM_CLKGEN serial M/D reprogramming initiator. Shifts LOAD_D, LOAD_M and
// GO over PROGCLK/PROGEN/PROGDATA, then waits for PROGDONE (and optionally
// LOCKED) with a progclk-period timeout.
// Ports: clkin/rst_n; start, m_minus1, d_minus1 request; busy, done, err,
// err_code status; progclk, progen, progdata to the DCM; progdone, locked
// back from the DCM (asynchronous).
module dcm_clkgen_prog
  import dcm_prog_pkg::*;
#(
  parameter int unsigned PROG_DIV      = 2,
  parameter int unsigned TIMEOUT_TICKS = 1024,
  parameter bit          WAIT_LOCK     = 1'b1
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] m_minus1,
  input  logic [7:0] d_minus1,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic       progclk,
  output logic       progen,
  output logic       progdata,
  input  logic       progdone,
  input  logic       locked
);

  localparam int unsigned DIV_W = (PROG_DIV > 1) ? $clog2(PROG_DIV) : 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_TICKS + 1);

  logic progdone_s, locked_s;

  dcm_clkgen_prog_sync2 u_sync_progdone (
    .clk_i (clkin), .rst_ni (rst_n), .d_i (progdone), .q_o (progdone_s)
  );

  dcm_clkgen_prog_sync2 u_sync_locked (
    .clk_i (clkin), .rst_ni (rst_n), .d_i (locked), .q_o (locked_s)
  );

  // Free-running progclk divider; fall_tick marks the progclk 1->0 edge
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             progclk_q, progclk_d;
  logic             div_wrap_c, fall_tick_c;

  always_comb begin
    div_wrap_c  = (div_cnt_q == DIV_W'(PROG_DIV - 1));
    div_cnt_d   = div_wrap_c ? '0 : div_cnt_q + DIV_W'(1);
    progclk_d   = div_wrap_c ? ~progclk_q : progclk_q;
    fall_tick_c = div_wrap_c & progclk_q;
  end

  state_e                 state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic                   seen_low_q, seen_low_d;
  logic [7:0]             m_q, m_d, dv_q, dv_d;
  logic                   busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [1:0]             err_code_q, err_code_d;
  logic                   progen_q, progen_d, progdata_q, progdata_d;
  logic [LOAD_BITS-1:0]   word_d_c, word_m_c;
  logic                   last_bit_c, timeout_c;

  // Next-state and output logic; serial outputs only move on fall_tick
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tmr_d      = tmr_q;
    seen_low_d = seen_low_q;
    m_d        = m_q;
    dv_d       = dv_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    progen_d   = progen_q;
    progdata_d = progdata_q;
    word_d_c   = load_word(CMD_LOAD_D, dv_q);
    word_m_c   = load_word(CMD_LOAD_M, m_q);
    last_bit_c = (bit_cnt_q == BIT_CNT_W'(LOAD_BITS - 1));
    timeout_c  = (tmr_q >= TMR_W'(TIMEOUT_TICKS));

    unique case (state_q)
      ST_IDLE: begin
        progen_d = 1'b0;
        if (start) begin
          if (m_minus1 == 8'd0) begin
            err_d      = 1'b1;
            err_code_d = ERR_BAD_M;
          end else begin
            m_d        = m_minus1;
            dv_d       = d_minus1;
            busy_d     = 1'b1;
            err_code_d = ERR_NONE;
            bit_cnt_d  = '0;
            tmr_d      = '0;
            seen_low_d = 1'b0;
            state_d    = ST_LOAD_D;
          end
        end
      end
      ST_LOAD_D: if (fall_tick_c) begin
        progen_d   = 1'b1;
        progdata_d = word_d_c[bit_cnt_q];
        bit_cnt_d  = last_bit_c ? '0 : bit_cnt_q + BIT_CNT_W'(1);
        if (last_bit_c) state_d = ST_GAP1;
      end
      ST_GAP1: if (fall_tick_c) begin
        progen_d   = 1'b0;
        progdata_d = 1'b0;
        state_d    = ST_LOAD_M;
      end
      ST_LOAD_M: if (fall_tick_c) begin
        progen_d   = 1'b1;
        progdata_d = word_m_c[bit_cnt_q];
        bit_cnt_d  = last_bit_c ? '0 : bit_cnt_q + BIT_CNT_W'(1);
        if (last_bit_c) state_d = ST_GAP2;
      end
      ST_GAP2: if (fall_tick_c) begin
        progen_d   = 1'b0;
        progdata_d = 1'b0;
        state_d    = ST_GO;
      end
      ST_GO: if (fall_tick_c) begin
        progen_d   = 1'b1;
        progdata_d = 1'b0;
        state_d    = ST_WAIT_DONE;
      end
      ST_WAIT_DONE, ST_WAIT_LOCK: begin
        if (fall_tick_c) begin
          progen_d   = 1'b0;
          progdata_d = 1'b0;
          tmr_d      = tmr_q + TMR_W'(1);
        end
        // PROGDONE is high before GO; only a low-then-high sequence counts
        if (!progdone_s) seen_low_d = 1'b1;
        if (timeout_c) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          busy_d     = 1'b0;
          progen_d   = 1'b0;
          progdata_d = 1'b0;
          state_d    = ST_IDLE;
        end else if ((state_q == ST_WAIT_DONE) && seen_low_q && progdone_s && WAIT_LOCK) begin
          state_d = ST_WAIT_LOCK;
        end else if (((state_q == ST_WAIT_DONE) && seen_low_q && progdone_s) ||
                     ((state_q == ST_WAIT_LOCK) && locked_s)) begin
          done_d     = 1'b1;
          busy_d     = 1'b0;
          progen_d   = 1'b0;
          progdata_d = 1'b0;
          state_d    = ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q  <= '0;
      progclk_q  <= 1'b0;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      tmr_q      <= '0;
      seen_low_q <= 1'b0;
      m_q        <= '0;
      dv_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      progen_q   <= 1'b0;
      progdata_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      progclk_q  <= progclk_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tmr_q      <= tmr_d;
      seen_low_q <= seen_low_d;
      m_q        <= m_d;
      dv_q       <= dv_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      progen_q   <= progen_d;
      progdata_q <= progdata_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign progclk  = progclk_q;
  assign progen   = progen_q;
  assign progdata = progdata_q;

endmodule

// File: tb/tb_dcm_clkgen_prog.sv
// Self-checking bench for dcm_clkgen_prog: one instance at PROG_DIV=2 and a
// second at PROG_DIV=1, each with its own simple DCM response model.
module tb_dcm_clkgen_prog;

  logic       clkin = 1'b0;
  logic       rst_n = 1'b0;
  always #5 clkin = ~clkin;

  logic       start = 1'b0, progdone = 1'b1, locked = 1'b1;
  logic [7:0] m_minus1 = 8'd0, d_minus1 = 8'd0;
  logic       busy, done, err, progclk, progen, progdata;
  logic [1:0] err_code;

  logic       start1 = 1'b0, progdone1 = 1'b1, locked1 = 1'b1;
  logic [7:0] m1 = 8'd0, d1 = 8'd0;
  logic       busy1, done1, err1, progclk1, progen1, progdata1;
  logic [1:0] err_code1;

  dcm_clkgen_prog dut (
    .clkin(clkin), .rst_n(rst_n), .start(start), .m_minus1(m_minus1),
    .d_minus1(d_minus1), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .progclk(progclk), .progen(progen),
    .progdata(progdata), .progdone(progdone), .locked(locked)
  );

  dcm_clkgen_prog #(.PROG_DIV(1)) dut1 (
    .clkin(clkin), .rst_n(rst_n), .start(start1), .m_minus1(m1),
    .d_minus1(d1), .busy(busy1), .done(done1), .err(err1),
    .err_code(err_code1), .progclk(progclk1), .progen(progen1),
    .progdata(progdata1), .progdone(progdone1), .locked(locked1)
  );

  int n_cmp = 0, n_bad = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, done1_cnt = 0, err1_cnt = 0;

  typedef struct packed {logic en; logic data; logic chk;} exp_t;
  exp_t exp_q[$];

  always @(negedge clkin) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done1) done1_cnt++;
    if (err1) err1_cnt++;
    if ((done && err) || (done1 && err1)) both_cnt++;
  end

  function automatic void push_bit(input logic en, input logic data, input logic chk);
    exp_t e;
    e.en = en; e.data = data; e.chk = chk;
    exp_q.push_back(e);
  endfunction

  // Expected PROGEN/PROGDATA at each progclk rise for one M/D load + GO
  function automatic void push_stream(input logic [7:0] m, input logic [7:0] d);
    push_bit(1'b1, 1'b1, 1'b1); push_bit(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) push_bit(1'b1, d[i], 1'b1);
    push_bit(1'b0, 1'b0, 1'b1);
    push_bit(1'b1, 1'b1, 1'b1); push_bit(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) push_bit(1'b1, m[i], 1'b1);
    push_bit(1'b0, 1'b0, 1'b0);
    push_bit(1'b1, 1'b0, 1'b1);
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clkin);
    n_cmp++;
    if ({busy, done, err, err_code, progclk, progen, progdata} !== 8'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b, expected 00000000",
               {busy, done, err, err_code, progclk, progen, progdata});
    end
    n_cmp++;
    if ({busy1, done1, err1, err_code1, progclk1, progen1, progdata1} !== 8'b0) begin
      n_bad++;
      $display("FAIL reset_outputs1: got %b, expected 00000000",
               {busy1, done1, err1, err_code1, progclk1, progen1, progdata1});
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clkin);
  endtask

  task automatic test_bit_stream();
    int t;
    exp_t e;
    m_minus1 = 8'h02; d_minus1 = 8'h31;
    push_stream(8'h02, 8'h31);
    @(negedge clkin) start = 1'b1;
    @(negedge clkin) start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_accept: got %b, expected 1", busy); end
    t = 0;
    do begin @(posedge progclk); #1; t++; end while (progen !== 1'b1 && t < 64);
    if (progen !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL stream_start: progen=%b after %0d ticks, expected 1", progen, t);
      exp_q.delete();
      return;
    end
    for (int i = 0; i < 23; i++) begin
      if (i > 0) begin @(posedge progclk); #1; end
      e = exp_q.pop_front();
      n_cmp++;
      if (progen !== e.en || (e.chk && progdata !== e.data)) begin
        n_bad++;
        $display("FAIL stream_bit%0d: en/data got %b/%b, expected %b/%b",
                 i, progen, progdata, e.en, e.data);
      end
    end
  endtask

  // Continues the load from test_bit_stream: DCM reprograms then relocks
  task automatic test_completion();
    int d0, t;
    d0 = done_cnt;
    repeat (3) @(posedge progclk);
    @(negedge clkin); progdone = 1'b0; locked = 1'b0;
    repeat (20) @(posedge progclk);
    @(negedge clkin); progdone = 1'b1;
    repeat (5) @(negedge clkin);
    n_cmp++;
    if (busy !== 1'b1 || done_cnt != d0) begin
      n_bad++; $display("FAIL wait_lock_busy: busy=%b dones=%0d, expected 1/0", busy, done_cnt - d0);
    end
    locked = 1'b1;
    t = 0;
    while (done !== 1'b1 && t < 100) begin @(negedge clkin); t++; end
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++; $display("FAIL done_seen: got %b, expected 1", done);
    end else begin
      n_cmp++;
      if (busy !== 1'b0 || err !== 1'b0) begin
        n_bad++; $display("FAIL done_cycle: busy/err got %b/%b, expected 0/0", busy, err);
      end
    end
    repeat (20) @(negedge clkin);
    n_cmp++;
    if (done_cnt - d0 != 1 || busy !== 1'b0 || err_code !== 2'd0) begin
      n_bad++;
      $display("FAIL done_once: pulses=%0d busy=%b code=%0d, expected 1/0/0",
               done_cnt - d0, busy, err_code);
    end
  endtask

  task automatic test_bad_m();
    int e0;
    int en_seen;
    e0 = err_cnt; en_seen = 0;
    m_minus1 = 8'h00; d_minus1 = 8'h05;
    @(negedge clkin) start = 1'b1;
    @(negedge clkin) start = 1'b0;
    n_cmp++;
    if (err !== 1'b1 || err_code !== 2'd1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL bad_m: err/code/busy got %b/%0d/%b, expected 1/1/0", err, err_code, busy);
    end
    for (int i = 0; i < 60; i++) begin
      @(negedge clkin);
      if (progen) en_seen++;
    end
    n_cmp++;
    if (en_seen != 0 || err_cnt - e0 != 1 || err_code !== 2'd1) begin
      n_bad++;
      $display("FAIL bad_m_quiet: progen cycles=%0d err pulses=%0d code=%0d, expected 0/1/1",
               en_seen, err_cnt - e0, err_code);
    end
  endtask

  task automatic test_back_to_back();
    logic prev;
    int tog_bad, d0, e0, t;
    exp_t e;
    tog_bad = 0; d0 = done1_cnt; e0 = err1_cnt;
    @(negedge clkin) prev = progclk1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clkin);
      if (progclk1 === prev) tog_bad++;
      prev = progclk1;
    end
    n_cmp++;
    if (tog_bad != 0) begin n_bad++; $display("FAIL progclk_div1: %0d missed toggles, expected 0", tog_bad); end
    m1 = 8'h02; d1 = 8'h31;
    push_stream(8'h02, 8'h31);
    @(negedge clkin) start1 = 1'b1;
    @(negedge clkin) start1 = 1'b0;
    fork
      begin
        t = 0;
        do begin @(posedge progclk1); #1; t++; end while (progen1 !== 1'b1 && t < 64);
        if (progen1 !== 1'b1) begin
          n_cmp++; n_bad++;
          $display("FAIL stream1_start: progen=%b, expected 1", progen1);
          exp_q.delete();
        end else begin
          for (int i = 0; i < 23; i++) begin
            if (i > 0) begin @(posedge progclk1); #1; end
            e = exp_q.pop_front();
            n_cmp++;
            if (progen1 !== e.en || (e.chk && progdata1 !== e.data)) begin
              n_bad++;
              $display("FAIL stream1_bit%0d: en/data got %b/%b, expected %b/%b",
                       i, progen1, progdata1, e.en, e.data);
            end
          end
        end
      end
      begin
        n_cmp++;
        if (busy1 !== 1'b1) begin n_bad++; $display("FAIL busy1_accept: got %b, expected 1", busy1); end
        m1 = 8'h00; d1 = 8'h77; start1 = 1'b1;
        @(negedge clkin) start1 = 1'b0;
        @(negedge clkin) begin m1 = 8'h55; d1 = 8'h11; start1 = 1'b1; end
        @(negedge clkin) start1 = 1'b0;
      end
    join
    repeat (3) @(posedge progclk1);
    @(negedge clkin) progdone1 = 1'b0;
    repeat (5) @(posedge progclk1);
    @(negedge clkin) progdone1 = 1'b1;
    t = 0;
    while (done1 !== 1'b1 && t < 100) begin @(negedge clkin); t++; end
    repeat (10) @(negedge clkin);
    n_cmp++;
    if (done1_cnt - d0 != 1 || err1_cnt - e0 != 0 || err_code1 !== 2'd0 || busy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_ignore: dones=%0d errs=%0d code=%0d busy=%b, expected 1/0/0/0",
               done1_cnt - d0, err1_cnt - e0, err_code1, busy1);
    end
  endtask

  task automatic test_timeout();
    int t, ticks, cyc, e0, d0;
    logic prev;
    e0 = err_cnt; d0 = done_cnt;
    progdone = 1'b1; locked = 1'b1;
    m_minus1 = 8'h02; d_minus1 = 8'h31;
    @(negedge clkin) start = 1'b1;
    @(negedge clkin) start = 1'b0;
    t = 0;
    do begin @(posedge progclk); #1; t++; end while (progen !== 1'b1 && t < 64);
    if (progen !== 1'b1) begin
      n_cmp++; n_bad++; $display("FAIL timeout_start: progen=%b, expected 1", progen);
      return;
    end
    repeat (22) begin @(posedge progclk); #1; end
    n_cmp++;
    if (progen !== 1'b1 || progdata !== 1'b0) begin
      n_bad++; $display("FAIL go_bit: en/data got %b/%b, expected 1/0", progen, progdata);
    end
    prev = progclk; ticks = 0; cyc = 0;
    while (err !== 1'b1 && cyc < 20000) begin
      @(negedge clkin); cyc++;
      if (progclk && !prev) ticks++;
      prev = progclk;
    end
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++; $display("FAIL timeout_err: got %b after %0d cycles, expected 1", err, cyc);
      return;
    end
    n_cmp++;
    if (ticks < 1022 || ticks > 1026) begin
      n_bad++; $display("FAIL timeout_ticks: got %0d, expected about 1024", ticks);
    end
    n_cmp++;
    if (err_code !== 2'd2 || busy !== 1'b0 || progen !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_state: code/busy/progen got %0d/%b/%b, expected 2/0/0", err_code, busy, progen);
    end
    repeat (10) @(negedge clkin);
    n_cmp++;
    if (err_cnt - e0 != 1 || done_cnt != d0) begin
      n_bad++; $display("FAIL timeout_once: errs=%0d dones=%0d, expected 1/0", err_cnt - e0, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    int t, e0, d0, en_seen;
    e0 = err_cnt; d0 = done_cnt; en_seen = 0;
    m_minus1 = 8'h02; d_minus1 = 8'h31;
    @(negedge clkin) start = 1'b1;
    @(negedge clkin) start = 1'b0;
    t = 0;
    do begin @(posedge progclk); #1; t++; end while (progen !== 1'b1 && t < 64);
    repeat (12) begin @(posedge progclk); #1; end
    n_cmp++;
    if (progen !== 1'b1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL mid_load_m: progen/busy got %b/%b, expected 1/1", progen, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (progen !== 1'b0) begin n_bad++; $display("FAIL reset_progen: got %b, expected 0", progen); end
    n_cmp++;
    if ({busy, done, err, err_code, progclk, progen, progdata} !== 8'b0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: got %b, expected 00000000",
               {busy, done, err, err_code, progclk, progen, progdata});
    end
    repeat (3) @(negedge clkin);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clkin);
      if (progen) en_seen++;
    end
    n_cmp++;
    if (err_cnt != e0 || done_cnt != d0 || en_seen != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL after_reset: errs=%0d dones=%0d progen cycles=%0d busy=%b, expected 0/0/0/0",
               err_cnt - e0, done_cnt - d0, en_seen, busy);
    end
  endtask

  task automatic test_exclusive();
    n_cmp++;
    if (both_cnt != 0) begin n_bad++; $display("FAIL done_err_overlap: got %0d cycles, expected 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_bit_stream();
    test_completion();
    test_bad_m();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
